aes_key_sched_ctrl: RTL and testbench

Sequencer that drives the team's combinational single-round key generator (ports rc[3:0], inkey[127:0], outkey[127:0]) iteratively. It expands one AES-128 cipher key into the 11 round keys, one round per clock, and stores them in an internal 11x128 key file. The block sits between the key-load interface and the cipher round datapath; the datapath fetches round keys through a registered read port.

---
 rtl/aes_key_sched_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: expands one cipher key into an 11-entry round-key file, one round per clock.
// Optional feature macro: AES_KEYSCHED_ZEROIZE_EN (clear/reset also wipe the key file and working key).
module aes_key_sched_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_in_valid,
  output logic         key_in_ready,
  input  logic [127:0] key_in,
  input  logic         clear,
  output logic         busy,
  output logic         keys_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_key,
  output logic         rd_valid
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXPAND = 2'd1, DONE = 2'd2} state_t;

  state_t         state;
  state_t         state_next;
  logic [3:0]     rnd;
  logic [127:0]   cur;
  logic [127:0]   outkey;
  logic [127:0]   key_file [0:10];
  logic           accept;
  logic           advance;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = gf_inv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd0:    return 8'h01;
      4'd1:    return 8'h02;
      4'd2:    return 8'h04;
      4'd3:    return 8'h08;
      4'd4:    return 8'h10;
      4'd5:    return 8'h20;
      4'd6:    return 8'h40;
      4'd7:    return 8'h80;
      4'd8:    return 8'h1b;
      4'd9:    return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Single-round key generator: word 0 sits in the top 32 bits.
  function automatic logic [127:0] key_round(input logic [3:0] rc, input logic [127:0] inkey);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = inkey[127:96];
    w1 = inkey[95:64];
    w2 = inkey[63:32];
    w3 = inkey[31:0];
    t  = {sbox(w3[23:16]) ^ rcon(rc), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  assign outkey = key_round(rnd, cur);

  // Next-state decode; clear overrides any handshake or expansion step.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    advance    = 1'b0;
    if (clear) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (key_in_valid) begin
            accept     = 1'b1;
            state_next = EXPAND;
          end else begin
            state_next = state;
          end
        end
        EXPAND: begin
          advance = 1'b1;
          if (rnd == 4'd9) state_next = DONE;
          else             state_next = EXPAND;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // State, round counter and status outputs registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rnd          <= 4'd0;
      key_in_ready <= 1'b1;
      busy         <= 1'b0;
      keys_valid   <= 1'b0;
    end else begin
      state        <= state_next;
      key_in_ready <= (state_next != EXPAND);
      busy         <= (state_next == EXPAND);
      keys_valid   <= (state_next == DONE);
      if (clear || accept) rnd <= 4'd0;
      else if (advance)    rnd <= rnd + 4'd1;
      else                 rnd <= rnd;
    end
  end

  // Working key fed back into the round generator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur <= 128'd0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
    end else if (clear) begin
      cur <= 128'd0;
`endif
    end else if (accept) begin
      cur <= key_in;
    end else if (advance) begin
      cur <= outkey;
    end
  end

`ifdef AES_KEYSCHED_ZEROIZE_EN
  // Key file storage, wiped by reset and clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 11; i++) key_file[i] <= 128'd0;
    end else if (clear) begin
      for (int i = 0; i < 11; i++) key_file[i] <= 128'd0;
    end else if (accept) begin
      key_file[0] <= key_in;
    end else if (advance) begin
      key_file[rnd + 4'd1] <= outkey;
    end
  end
`else
  // Key file storage, retained across reset and clear.
  always_ff @(posedge clk) begin
    if (accept) begin
      key_file[0] <= key_in;
    end else if (advance) begin
      key_file[rnd + 4'd1] <= outkey;
    end
  end
`endif

  // Registered read port; reads see the pre-write contents of the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_key   <= 128'd0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) rd_key <= (rd_idx <= 4'd10) ? key_file[rd_idx] : 128'd0;
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: word-level FIPS-197 key expansion model plus a per-cycle compare process.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_in_valid;
  logic         key_in_ready;
  logic [127:0] key_in;
  logic         clear;
  logic         busy;
  logic         keys_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;

  aes_key_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n), .key_in_valid(key_in_valid), .key_in_ready(key_in_ready),
    .key_in(key_in), .clear(clear), .busy(busy), .keys_valid(keys_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_key(rd_key), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KZ = 128'h0;

  logic [7:0] sb [0:255];
  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  event chk_now;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Round key r of the standard 44-word expansion of key.
  function automatic logic [127:0] rk(input logic [127:0] key, input int r);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // Behavioural model: rounds remaining, key file contents and read pipeline.
  logic [127:0] m_file [0:10];
  bit           m_known [0:10] = '{default: 1'b0};
  logic [127:0] m_key;
  int           m_left;
  bit           m_done;
  bit           m_rd_valid;
  logic [127:0] m_rd_key;
  bit           m_rd_known;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left     <= 0;
      m_done     <= 1'b0;
      m_rd_valid <= 1'b0;
      m_rd_key   <= 128'd0;
      m_rd_known <= 1'b1;
`ifdef AES_KEYSCHED_ZEROIZE_EN
      for (int i = 0; i < 11; i++) begin m_file[i] <= 128'd0; m_known[i] <= 1'b1; end
`endif
    end else begin
      m_rd_valid <= rd_en;
      if (rd_en) begin
        if (rd_idx > 4'd10) begin m_rd_key <= 128'd0; m_rd_known <= 1'b1; end
        else begin m_rd_key <= m_file[rd_idx]; m_rd_known <= m_known[rd_idx]; end
      end
      if (clear) begin
        m_left <= 0;
        m_done <= 1'b0;
`ifdef AES_KEYSCHED_ZEROIZE_EN
        for (int i = 0; i < 11; i++) begin m_file[i] <= 128'd0; m_known[i] <= 1'b1; end
`endif
      end else if (m_left > 0) begin
        m_file[11 - m_left]  <= rk(m_key, 11 - m_left);
        m_known[11 - m_left] <= 1'b1;
        m_left <= m_left - 1;
        if (m_left == 1) m_done <= 1'b1;
      end else if (key_in_valid) begin
        m_key      <= key_in;
        m_file[0]  <= key_in;
        m_known[0] <= 1'b1;
        m_left     <= 10;
        m_done     <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: pins the model to known literals, then checks every cycle.
  initial begin
    wait (chk_on);
    chk("model_sbox_00", {120'd0, sb[8'h00]}, 128'h63);
    chk("model_sbox_53", {120'd0, sb[8'h53]}, 128'hed);
    chk("model_k1_rk0", rk(K1, 0), 128'h2b7e151628aed2a6abf7158809cf4f3c);
    chk("model_k1_rk1", rk(K1, 1), 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_k1_rk10", rk(K1, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("model_kz_rk1", rk(KZ, 1), 128'h62636363626363636263636362636363);
    forever begin
      @(negedge clk or chk_now);
      chk("key_in_ready", {127'd0, key_in_ready}, {127'd0, m_left == 0});
      chk("busy", {127'd0, busy}, {127'd0, m_left > 0});
      chk("keys_valid", {127'd0, keys_valid}, {127'd0, m_done});
      chk("rd_valid", {127'd0, rd_valid}, {127'd0, m_rd_valid});
      if (m_rd_known) chk("rd_key", rd_key, m_rd_key);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [127:0] k);
    key_in_valid = 1'b1;
    key_in       = k;
    @(negedge clk);
    key_in_valid = 1'b0;
  endtask

  task automatic rd(input int i);
    rd_en  = 1'b1;
    rd_idx = i[3:0];
    @(negedge clk);
    rd_en  = 1'b0;
  endtask

  initial begin
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;

    key_in_valid = 1'b0; key_in = 128'd0; clear = 1'b0; rd_en = 1'b0; rd_idx = 4'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    cyc(2);
    rst_n = 1'b1;

    // Reference key: full expansion then reads including out-of-range indices back-to-back.
    load(K1);
    cyc(11);
    rd(0); rd(1); rd(10); rd(11); rd(15); rd(5);
    cyc(2);

    // Key held valid across an expansion is taken only in DONE.
    load(K2);
    key_in_valid = 1'b1;
    key_in       = K1;
    cyc(11);
    key_in_valid = 1'b0;
    cyc(11);
    for (int i = 0; i < 11; i++) rd(i);

    // Clear at round 5 with reads running during the expansion.
    load(K2);
    for (int i = 0; i < 5; i++) rd(i + 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    rd(0); rd(5); rd(6);
    cyc(2);

    // Asynchronous reset mid-expansion, then a fresh load.
    load(K1);
    cyc(4);
    #2 rst_n = 1'b0;
    #1 -> chk_now;
    cyc(2);
    rst_n = 1'b1;
    rd(0);
    load(KZ);
    cyc(11);
    for (int i = 0; i < 11; i++) rd(i);

    // Clear and a key offer in the same DONE cycle: clear wins.
    key_in_valid = 1'b1;
    key_in       = K2;
    clear        = 1'b1;
    @(negedge clk);
    key_in_valid = 1'b0;
    clear        = 1'b0;
    cyc(2);
    rd(0); rd(10);
    cyc(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
